// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory: byte-enabled synchronous stores, combinational sign/zero-extended loads.
// Optional DMEM_ALIGN_TRAP_EN: trap misaligned accesses (suppress store, poison load, sticky flag).
module mem_stage_dmem #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = 10
) (
    input  logic        Clk_in,
    input  logic        Rst,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  MemSize_in,
    input  logic        MemSigned_in,
    input  logic [31:0] Address_in,
    input  logic [31:0] WriteData_in,
    output logic [31:0] ReadData_out,
    output logic        Misaligned_out
);

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic [31:0]          rd_word;
    logic [3:0]           byte_en;
    logic [31:0]          wr_data;
    logic                 wr_en;
    logic [31:0]          rd_data;

    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, Address_in[31:ADDR_BITS+2]};

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] hs;
        logic signed [31:0] ws;
        hs = h;
        ws = hs;
        return sgn ? ws : {16'h0000, h};
    endfunction

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  bs;
        logic signed [31:0] ws;
        bs = b;
        ws = bs;
        return sgn ? ws : {24'h000000, b};
    endfunction

    assign word_idx = Address_in[ADDR_BITS+1:2];
    assign rd_word  = mem[word_idx];

    // Sub-word accesses use only the offset bits that matter for their size, so in
    // the non-trapping build the offending low bits are ignored, i.e. forced to zero.
    always_comb begin
        byte_en = 4'b1111;
        wr_data = WriteData_in;
        case (MemSize_in)
            SZ_HALF: begin
                byte_en = Address_in[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{WriteData_in[15:0]}};
            end
            SZ_BYTE: begin
                byte_en = 4'b0001 << Address_in[1:0];
                wr_data = {4{WriteData_in[7:0]}};
            end
            default: ;
        endcase
    end

`ifdef DMEM_ALIGN_TRAP_EN
    logic misaligned;
    logic mis_flag;

    always_comb begin
        misaligned = 1'b0;
        if (MemRead_in || MemWrite_in) begin
            case (MemSize_in)
                SZ_HALF: misaligned = Address_in[0];
                SZ_BYTE: misaligned = 1'b0;
                default: misaligned = |Address_in[1:0];
            endcase
        end
    end

    assign wr_en = MemWrite_in && !misaligned;

    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst)
            mis_flag <= 1'b0;
        else if (misaligned)
            mis_flag <= 1'b1;
    end

    assign Misaligned_out = mis_flag;
`else
    assign wr_en          = MemWrite_in;
    assign Misaligned_out = 1'b0;
`endif

    always_ff @(posedge Clk_in or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    always_comb begin
        rd_data = '0;
        if (MemRead_in) begin
            case (MemSize_in)
                SZ_HALF: rd_data = ext_half(Address_in[1] ? rd_word[31:16] : rd_word[15:0], MemSigned_in);
                SZ_BYTE: rd_data = ext_byte(rd_word[8*Address_in[1:0] +: 8], MemSigned_in);
                default: rd_data = rd_word;
            endcase
`ifdef DMEM_ALIGN_TRAP_EN
            if (misaligned)
                rd_data = 32'hDEADBEEF;
`endif
        end
    end

    assign ReadData_out = rd_data;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Self-checking bench for mem_stage_dmem against a byte-addressed reference memory.
// Honours DMEM_ALIGN_TRAP_EN the same way the design does.
module tb_mem_stage_dmem;

    logic        Clk_in;
    logic        Rst;
    logic        MemRead_in;
    logic        MemWrite_in;
    logic [1:0]  MemSize_in;
    logic        MemSigned_in;
    logic [31:0] Address_in;
    logic [31:0] WriteData_in;
    logic [31:0] ReadData_out;
    logic        Misaligned_out;

    int checks = 0;
    int errors = 0;

    mem_stage_dmem #(.DEPTH(1024), .ADDR_BITS(10)) dut (
        .Clk_in        (Clk_in),
        .Rst           (Rst),
        .MemRead_in    (MemRead_in),
        .MemWrite_in   (MemWrite_in),
        .MemSize_in    (MemSize_in),
        .MemSigned_in  (MemSigned_in),
        .Address_in    (Address_in),
        .WriteData_in  (WriteData_in),
        .ReadData_out  (ReadData_out),
        .Misaligned_out(Misaligned_out)
    );

    initial Clk_in = 1'b0;
    always #5 Clk_in = ~Clk_in;

    // Reference model: 4 KiB of bytes (1024 words), little-endian, plus the sticky flag.
    logic [7:0] mdl [4096];
    logic       exp_mis;

`ifdef DMEM_ALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 4;
    endfunction

    function automatic bit is_mis(input logic [1:0] size, input logic [31:0] addr);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic int unsigned base_of(input logic [1:0] size, input logic [31:0] addr);
        int unsigned a;
        a = addr;
        a = a - (a % nbytes(size));
        return a % 4096;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
        int unsigned b;
        longint v;
        int n;
        if (TRAP && is_mis(size, addr)) return 32'hDEADBEEF;
        n = nbytes(size);
        b = base_of(size, addr);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(mdl[b + i]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int unsigned b;
        if (TRAP && is_mis(size, addr)) return;
        b = base_of(size, addr);
        for (int i = 0; i < nbytes(size); i++) mdl[b + i] = data[8*i +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
        exp_mis = 1'b0;
    endtask

    // One access cycle: drive, sample the combinational read before the edge,
    // sample the flag after the edge, then advance the model.
    task automatic cycle(input logic rd, input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] pre_rd, output logic post_mis);
        MemRead_in   = rd;
        MemWrite_in  = wr;
        MemSize_in   = size;
        MemSigned_in = sgn;
        Address_in   = addr;
        WriteData_in = wdata;
        #2;
        pre_rd = ReadData_out;
        @(posedge Clk_in);
        #1;
        post_mis = Misaligned_out;
        if (wr) model_store(size, addr, wdata);
        if (TRAP && (rd || wr) && is_mis(size, addr)) exp_mis = 1'b1;
        MemRead_in  = 1'b0;
        MemWrite_in = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        MemRead_in = 1'b1; MemWrite_in = 1'b0; MemSize_in = 2'b00; MemSigned_in = 1'b0;
        Address_in = 32'h10; WriteData_in = 32'h0;
        model_clear();
        #3;
        checks++;
        if (ReadData_out !== 32'h0) begin
            errors++; $display("FAIL reset_read got %h want %h", ReadData_out, 32'h0);
        end
        checks++;
        if (Misaligned_out !== 1'b0) begin
            errors++; $display("FAIL reset_mis got %b want 0", Misaligned_out);
        end
        @(posedge Clk_in);
        #1;
        Rst = 1'b1;
        MemRead_in = 1'b0;
    endtask

    task automatic test_word();
        logic [31:0] r; logic m;
        cycle(1, 0, 2'b00, 0, 32'h10, 0, r, m);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL word_init got %h want %h", r, 32'h0); end
        cycle(0, 1, 2'b00, 0, 32'h10, 32'h12345678, r, m);
        cycle(1, 0, 2'b00, 0, 32'h10, 0, r, m);
        checks++;
        if (r !== 32'h12345678) begin errors++; $display("FAIL word_rw got %h want %h", r, 32'h12345678); end
    endtask

    task automatic test_byte();
        logic [31:0] r; logic m;
        cycle(0, 1, 2'b10, 0, 32'h11, 32'hFFFFFFAB, r, m);
        cycle(1, 0, 2'b00, 0, 32'h10, 0, r, m);
        checks++;
        if (r !== 32'h1234AB78) begin errors++; $display("FAIL byte_merge got %h want %h", r, 32'h1234AB78); end
        cycle(1, 0, 2'b10, 1, 32'h11, 0, r, m);
        checks++;
        if (r !== 32'hFFFFFFAB) begin errors++; $display("FAIL byte_signed got %h want %h", r, 32'hFFFFFFAB); end
        cycle(1, 0, 2'b10, 0, 32'h11, 0, r, m);
        checks++;
        if (r !== 32'h000000AB) begin errors++; $display("FAIL byte_unsigned got %h want %h", r, 32'h000000AB); end
        cycle(1, 0, 2'b10, 0, 32'h13, 0, r, m);
        checks++;
        if (r !== 32'h00000012) begin errors++; $display("FAIL byte_top got %h want %h", r, 32'h00000012); end
    endtask

    task automatic test_half();
        logic [31:0] r; logic m;
        cycle(0, 1, 2'b01, 0, 32'h22, 32'h77778001, r, m);
        cycle(1, 0, 2'b00, 0, 32'h20, 0, r, m);
        checks++;
        if (r !== 32'h80010000) begin errors++; $display("FAIL half_word got %h want %h", r, 32'h80010000); end
        cycle(1, 0, 2'b01, 1, 32'h22, 0, r, m);
        checks++;
        if (r !== 32'hFFFF8001) begin errors++; $display("FAIL half_signed got %h want %h", r, 32'hFFFF8001); end
        cycle(1, 0, 2'b01, 0, 32'h22, 0, r, m);
        checks++;
        if (r !== 32'h00008001) begin errors++; $display("FAIL half_unsigned got %h want %h", r, 32'h00008001); end
    endtask

    task automatic test_wrap_simul();
        logic [31:0] r; logic m;
        cycle(0, 1, 2'b00, 0, 32'h4, 32'h11223344, r, m);
        cycle(1, 1, 2'b00, 0, 32'h00001004, 32'hCAFEF00D, r, m);
        checks++;
        if (r !== 32'h11223344) begin errors++; $display("FAIL simul_old got %h want %h", r, 32'h11223344); end
        cycle(1, 0, 2'b00, 0, 32'h4, 0, r, m);
        checks++;
        if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_new got %h want %h", r, 32'hCAFEF00D); end
    endtask

    task automatic test_misalign();
        logic [31:0] r; logic m;
        cycle(0, 1, 2'b00, 0, 32'h13, 32'h5555AAAA, r, m);
`ifdef DMEM_ALIGN_TRAP_EN
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL mis_set got %b want 1", m); end
        cycle(1, 0, 2'b00, 0, 32'h13, 0, r, m);
        checks++;
        if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_poison got %h want %h", r, 32'hDEADBEEF); end
        cycle(1, 0, 2'b00, 0, 32'h10, 0, r, m);
        checks++;
        if (r !== 32'h1234AB78) begin errors++; $display("FAIL mis_unchanged got %h want %h", r, 32'h1234AB78); end
        checks++;
        if (m !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b want 1", m); end
`else
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL mis_tied got %b want 0", m); end
        cycle(1, 0, 2'b00, 0, 32'h10, 0, r, m);
        checks++;
        if (r !== 32'h5555AAAA) begin errors++; $display("FAIL mis_forced got %h want %h", r, 32'h5555AAAA); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] r, exp_r, a, d;
        logic m, rd, wr, sgn;
        logic [1:0] sz;
        for (int i = 0; i < 400; i++) begin
            rd  = $urandom_range(0, 1);
            wr  = $urandom_range(0, 1);
            sz  = 2'($urandom_range(0, 3));
            sgn = $urandom_range(0, 1);
            a   = ($urandom & 32'h3F) | (32'($urandom_range(0, 3)) << 12);
            d   = $urandom;
            exp_r = rd ? model_load(sz, sgn, a) : 32'h0;
            cycle(rd, wr, sz, sgn, a, d, r, m);
            checks++;
            if (r !== exp_r) begin
                errors++; $display("FAIL rand_read i=%0d addr=%h size=%0d got %h want %h", i, a, sz, r, exp_r);
            end
            checks++;
            if (m !== exp_mis) begin
                errors++; $display("FAIL rand_mis i=%0d got %b want %b", i, m, exp_mis);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic m;
        cycle(0, 1, 2'b00, 0, 32'h10, 32'h89ABCDEF, r, m);
`ifdef DMEM_ALIGN_TRAP_EN
        cycle(1, 0, 2'b01, 0, 32'h11, 0, r, m);
`endif
        MemRead_in = 1'b1; MemWrite_in = 1'b1; MemSize_in = 2'b00; MemSigned_in = 1'b0;
        Address_in = 32'h30; WriteData_in = 32'h11111111;
        #2;
        Rst = 1'b0;
        #1;
        checks++;
        if (ReadData_out !== 32'h0) begin errors++; $display("FAIL rstmid_read got %h want %h", ReadData_out, 32'h0); end
        checks++;
        if (Misaligned_out !== 1'b0) begin errors++; $display("FAIL rstmid_mis got %b want 0", Misaligned_out); end
        Address_in = 32'h10;
        #1;
        checks++;
        if (ReadData_out !== 32'h0) begin errors++; $display("FAIL rstmid_clear got %h want %h", ReadData_out, 32'h0); end
        model_clear();
        @(posedge Clk_in);
        #1;
        MemWrite_in = 1'b0; MemRead_in = 1'b0;
        Rst = 1'b1;
        cycle(1, 0, 2'b00, 0, 32'h30, 0, r, m);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL rstmid_abort got %h want %h", r, 32'h0); end
        cycle(0, 1, 2'b01, 0, 32'h32, 32'h0000BEEF, r, m);
        cycle(1, 0, 2'b00, 0, 32'h30, 0, r, m);
        checks++;
        if (r !== 32'hBEEF0000) begin errors++; $display("FAIL rstmid_after got %h want %h", r, 32'hBEEF0000); end
        checks++;
        if (m !== 1'b0) begin errors++; $display("FAIL rstmid_flag got %b want 0", m); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_wrap_simul();
        test_misalign();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_dmem.md
Name: mem_stage_dmem

Overview:
MEM-stage data memory, directly upstream of the MEM/WB pipeline register.
- Consumes the EX/MEM address, store data and memory-control signals.
- Produces the 32-bit load value that MEM/WB captures as its read-data input.
- Supports word, halfword and byte accesses with sign/zero extension, synchronous byte-enabled writes and a sticky misalignment flag.

Parameters:
DEPTH, 1024, number of 32-bit words; must be a power of two.
ADDR_BITS, 10, log2(DEPTH); word index = Address[ADDR_BITS+1:2].

Ports:
Clk_in  input  1  clock; all state updates on the rising edge.
Rst  input  1  asynchronous, active-low reset.
MemRead_in  input  1  load enable.
MemWrite_in  input  1  store enable.
MemSize_in  input  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
MemSigned_in  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
Address_in  input  32  byte address from the ALU result.
WriteData_in  input  32  store data; the low byte/half is used for sub-word stores.
ReadData_out  output  32  load result, combinational.
Misaligned_out  output  1  sticky misaligned-access flag.

Behaviour:
- Reset (Rst low, asynchronous):
  - All DEPTH words are cleared to 0.
  - Misaligned_out is cleared to 0.
  - ReadData_out reads 0, since memory is zero.
  - Reset asserted mid-store aborts the store; memory is 0 after release.
- Addressing and byte order:
  - Word index = Address_in[ADDR_BITS+1:2]; upper address bits are ignored, so out-of-range addresses wrap.
  - Little-endian: byte offset 0 occupies bits [7:0], offset 3 occupies bits [31:24].
- Load path (combinational, zero latency):
  - MemRead_in = 0: ReadData_out = 0.
  - Word access: the full word is returned.
  - Half access: bytes at offset {Address_in[1],0} are returned, extended to 32 bits per MemSigned_in.
  - Byte access: the byte at offset Address_in[1:0] is returned, extended per MemSigned_in.
- Store path (synchronous):
  - When MemWrite_in = 1, the addressed bytes are written at the rising edge of Clk_in.
  - Byte enables:
    - Word: 1111.
    - Half: 0011 or 1100, selected by Address_in[1].
    - Byte: one-hot on Address_in[1:0].
  - Unselected bytes in the word are preserved.
- Simultaneous MemRead_in and MemWrite_in to the same word: ReadData_out shows the pre-write contents until the edge, then the new contents.
- Misalignment definition:
  - Word access with Address_in[1:0] != 00.
  - Half access with Address_in[0] = 1.
  - Byte accesses are never misaligned.
  - Only evaluated when MemRead_in or MemWrite_in is 1.
- Misaligned_out:
  - Set at the rising edge following any misaligned access.
  - Stays set until reset; it has no other clear.
  - Driven 0 when the optional feature is compiled out.
- No stall or handshake: one access per cycle, every cycle.

Optional Feature:
Macro DMEM_ALIGN_TRAP_EN.
- Defined:
  - A misaligned store is suppressed; memory is unchanged.
  - A misaligned load returns 32'hDEADBEEF.
  - Misaligned_out sets as described in Behaviour.
- Undefined:
  - Offending low address bits are forced to zero: word uses [1:0] = 00, half uses [0] = 0. The access then proceeds normally.
  - Misaligned_out is tied to 0.

Test Plan:
1. Reset and word access: pulse Rst low, then read word at 0x10 -> 0x00000000. Store word 0x12345678 at 0x10, then load word -> 0x12345678.
2. Byte store: with word 0x12345678 at 0x10, store byte 0xAB at 0x11, then load word -> 0x1234AB78. Load byte signed at 0x11 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB.
3. Half access: store half 0x8001 at 0x22, then load word at 0x20 -> 0x80010000. Load half signed at 0x22 -> 0xFFFF8001; load half unsigned -> 0x00008001.
4. Wrap and simultaneous access: with DEPTH = 1024, store 0xCAFEF00D at 0x00001004, then load word at 0x00000004 -> 0xCAFEF00D. In the store cycle, a same-cycle read of that word returns the old value.
5. Misalignment:
   - With DMEM_ALIGN_TRAP_EN: store word to 0x13 -> memory unchanged, load returns 0xDEADBEEF, Misaligned_out = 1 on the next edge and stays 1.
   - Without the macro: the store lands at 0x10 and Misaligned_out stays 0.
6. Reset mid-operation: assert Rst low asynchronously between edges while MemWrite_in = 1 -> all reads 0 and Misaligned_out = 0 immediately; first access after release behaves normally.
